// File: rtl/display_scan_if.sv
// Bundle of the display_scan control, write and display signals.
// master: the controlling side (run, writes, mask); slave: the scanner.
interface display_scan_if;
  logic       run;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [2:0] en;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output run, wr_en, wr_addr, wr_data, digit_mask,
    input  sel, en, seg, frame_done
  );

  modport slave (
    input  run, wr_en, wr_addr, wr_data, digit_mask,
    output sel, en, seg, frame_done
  );
endinterface

// File: rtl/display_scan.sv
// display_scan: multiplexed 8-digit 7-segment scanner driving a 3-to-8
// decoder (sel/en) plus a shared active-high segment bus.
// Optional feature macro: SCAN_SKIP_EN -- when defined, digits whose
// digit_mask bit is clear are skipped instead of being given a blank slot.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | decoder disabled, sel held, waiting for run
// DRIVE | decoder enabled on sel, seg shows reg[sel]; DIV cycles
// BLANK | decoder disabled, sel already advanced; DEAD cycles
module display_scan #(
  parameter int unsigned DIV  = 4,
  parameter int unsigned DEAD = 1
) (
  input logic           clk,
  input logic           rst,
  display_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  localparam logic [15:0] DIV_LOAD  = 16'(DIV - 1);
  localparam logic [15:0] DEAD_LOAD = 16'(DEAD - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        frame_q, frame_d;
  logic [7:0]  mask_q;
  logic [3:0]  rf_q [8];

  logic [2:0]  nxt_sel;
  logic        nxt_wrap;
  logic        halt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit register file; writes land on any edge regardless of scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 4'h0;
    end else if (bus.wr_en) begin
      rf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered copy of the mask so outputs depend only on flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= 8'h00;
    else     mask_q <= bus.digit_mask;
  end

  // Next digit index and whether that step wraps past digit 7.
  always_comb begin
    nxt_sel  = sel_q;
    nxt_wrap = 1'b0;
`ifdef SCAN_SKIP_EN
    for (int i = 8; i >= 1; i--) begin
      if (mask_q[3'(sel_q + 3'(i))]) nxt_sel = 3'(sel_q + 3'(i));
    end
    // Landing on an index not above the current one means we passed 7.
    nxt_wrap = (mask_q != 8'h00) && (nxt_sel <= sel_q);
    halt     = !bus.run || (mask_q == 8'h00);
`else
    nxt_sel  = 3'(sel_q + 3'd1);
    nxt_wrap = (sel_q == 3'd7);
    halt     = !bus.run;
`endif
  end

  // Scan FSM next-state: down-counter loaded on entry, leave at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    frame_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!halt) begin
          state_d = DRIVE;
          cnt_d   = DIV_LOAD;
        end
      end
      DRIVE: begin
        if (halt) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == 16'd0) begin
          state_d = BLANK;
          cnt_d   = DEAD_LOAD;
          sel_d   = nxt_sel;
          frame_d = nxt_wrap;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      BLANK: begin
        if (halt) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == 16'd0) begin
          state_d = DRIVE;
          cnt_d   = DIV_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      sel_q   <= 3'd0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  // Outputs decoded from registered state; masked digits show blank.
  always_comb begin
    bus.sel        = sel_q;
    bus.frame_done = frame_q;
    bus.en         = (state_q == DRIVE) ? 3'b100 : 3'b000;
    bus.seg        = 7'h00;
    if (state_q == DRIVE && mask_q[sel_q]) bus.seg = hex7(rf_q[sel_q]);
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV=4, DEAD=1.
module tb_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                      7'h39, 7'h5E, 7'h79, 7'h71};

  display_scan_if bus_if ();

  display_scan #(.DIV(4), .DEAD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int slot, ph, frames;
    logic [2:0] e_sel;
    logic [2:0] e_en;
    logic       e_fd;

    bus_if.run        = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_addr    = 3'd0;
    bus_if.wr_data    = 4'd0;
    bus_if.digit_mask = 8'hFF;

    tick(2);
    chk("rst_en", 32'(bus_if.en), 32'h0);
    chk("rst_seg", 32'(bus_if.seg), 32'h0);
    chk("rst_sel", 32'(bus_if.sel), 32'h0);
    chk("rst_fd", 32'(bus_if.frame_done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = 3'(i);
      bus_if.wr_data = 4'(i);
      tick();
    end
    bus_if.wr_en = 1'b0;
    chk("idle_en", 32'(bus_if.en), 32'h0);

    // Full frame: each digit 4 cycles enabled then 1 blank cycle.
    bus_if.run = 1'b1;
    tick();
    frames = 0;
    for (int k = 0; k < 40; k++) begin
      slot  = k / 5;
      ph    = k % 5;
      e_en  = (ph < 4) ? 3'b100 : 3'b000;
      e_sel = (ph < 4) ? 3'(slot) : 3'(slot + 1);
      e_fd  = (ph == 4) && (slot == 7);
      chk("scan_en", 32'(bus_if.en), 32'(e_en));
      chk("scan_sel", 32'(bus_if.sel), 32'(e_sel));
      chk("scan_fd", 32'(bus_if.frame_done), 32'(e_fd));
      chk("scan_seg", 32'(bus_if.seg), (ph < 4) ? 32'(HEX[slot]) : 32'h0);
      if (bus_if.frame_done) frames++;
      tick();
    end
    chk("frames_per_40", 32'(frames), 32'd1);

    // Write to the digit being displayed: old value now, new value next cycle.
    tick(15);
    chk("wr_sel", 32'(bus_if.sel), 32'd3);
    chk("wr_en_drive", 32'(bus_if.en), 32'h4);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 3'd3;
    bus_if.wr_data = 4'h8;
    chk("wr_seg_old", 32'(bus_if.seg), 32'h4F);
    tick();
    bus_if.wr_en = 1'b0;
    chk("wr_seg_new", 32'(bus_if.seg), 32'h7F);

    // Stop at digit 5 and resume there.
    tick(9);
    chk("stop_sel", 32'(bus_if.sel), 32'd5);
    chk("stop_pre_en", 32'(bus_if.en), 32'h4);
    bus_if.run = 1'b0;
    tick();
    chk("stop_en", 32'(bus_if.en), 32'h0);
    chk("stop_seg", 32'(bus_if.seg), 32'h0);
    chk("stop_sel_held", 32'(bus_if.sel), 32'd5);
    tick(2);
    chk("idle_sel_held", 32'(bus_if.sel), 32'd5);
    chk("idle_en_held", 32'(bus_if.en), 32'h0);
    bus_if.run = 1'b1;
    tick();
    chk("resume_en", 32'(bus_if.en), 32'h4);
    chk("resume_sel", 32'(bus_if.sel), 32'd5);
    chk("resume_seg", 32'(bus_if.seg), 32'h6D);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("resume_drive_en", 32'(bus_if.en), 32'h4);
      chk("resume_drive_sel", 32'(bus_if.sel), 32'd5);
    end
    tick();
    chk("resume_blank_en", 32'(bus_if.en), 32'h0);
    chk("resume_blank_sel", 32'(bus_if.sel), 32'd6);

    // Asynchronous reset in the middle of a DRIVE slot.
    tick();
    chk("pre_arst_en", 32'(bus_if.en), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", 32'(bus_if.en), 32'h0);
    chk("arst_seg", 32'(bus_if.seg), 32'h0);
    chk("arst_sel", 32'(bus_if.sel), 32'h0);
    chk("arst_fd", 32'(bus_if.frame_done), 32'h0);
    bus_if.run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(bus_if.en), 32'h0);

`ifdef SCAN_SKIP_EN
    // Skip mode: only digits 0, 2, 7 are visited.
    bus_if.digit_mask = 8'b1000_0101;
    bus_if.run        = 1'b1;
    tick();
    chk("skip_d0_en", 32'(bus_if.en), 32'h4);
    chk("skip_d0_sel", 32'(bus_if.sel), 32'd0);
    tick(4);
    chk("skip_b2_sel", 32'(bus_if.sel), 32'd2);
    chk("skip_b2_en", 32'(bus_if.en), 32'h0);
    chk("skip_b2_fd", 32'(bus_if.frame_done), 32'h0);
    tick(5);
    chk("skip_b7_sel", 32'(bus_if.sel), 32'd7);
    chk("skip_b7_fd", 32'(bus_if.frame_done), 32'h0);
    tick(5);
    chk("skip_b0_sel", 32'(bus_if.sel), 32'd0);
    chk("skip_b0_fd", 32'(bus_if.frame_done), 32'h1);
    tick();
    chk("skip_d0b_en", 32'(bus_if.en), 32'h4);
    chk("skip_d0b_fd", 32'(bus_if.frame_done), 32'h0);
    bus_if.digit_mask = 8'h00;
    tick(2);
    chk("skip_mask0_en", 32'(bus_if.en), 32'h0);
    tick(10);
    chk("skip_mask0_en_held", 32'(bus_if.en), 32'h0);
`else
    // Masked digit 0 still gets its slot, but blank; register file was cleared.
    bus_if.digit_mask = 8'hFE;
    bus_if.run        = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("mask_d0_en", 32'(bus_if.en), 32'h4);
      chk("mask_d0_sel", 32'(bus_if.sel), 32'd0);
      chk("mask_d0_seg", 32'(bus_if.seg), 32'h0);
      tick();
    end
    chk("mask_b1_en", 32'(bus_if.en), 32'h0);
    chk("mask_b1_sel", 32'(bus_if.sel), 32'd1);
    tick();
    chk("mask_d1_en", 32'(bus_if.en), 32'h4);
    chk("mask_d1_seg_cleared", 32'(bus_if.seg), 32'h3F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: DIV, default 4, clock cycles each digit is driven (legal 2..65535).
REQ-002 Parameter: DEAD, default 1, blanking cycles between digits (legal 1..255).
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: run  input  1  level; 1 = scanning enabled.
REQ-006 Port: wr_en  input  1  write strobe for digit register file.
REQ-007 Port: wr_addr  input  3  digit index written.
REQ-008 Port: wr_data  input  4  hex nibble written.
REQ-009 Port: digit_mask  input  8  bit i = 1 means digit i is displayed.
REQ-010 Port: sel  output  3  digit select, drives the 3-to-8 decoder select inputs.
REQ-011 Port: en  output  3  decoder enable group; 3'b100 = decoder active, 3'b000 = decoder disabled.
REQ-012 Port: seg  output  7  active-high segments {g,f,e,d,c,b,a} for the current digit.
REQ-013 Port: frame_done  output  1  one-cycle pulse at end of each full frame.

Function
REQ-014 Register file: 8 x 4 bits; write occurs on the clk edge with wr_en=1, regardless of state; new value visible on seg the following cycle if wr_addr == sel.
REQ-015 FSM states IDLE, DRIVE, BLANK; all outputs registered or decoded from registered state only.
REQ-016 IDLE: en=3'b000, seg=0, sel held; run=1 -> DRIVE next edge, cycle counter cleared.
REQ-017 DRIVE: en=3'b100, seg = hex pattern of reg[sel] (0->7'h3F, 1->7'h06, 8->7'h7F, A->7'h77, F->7'h71, standard 7-seg for others); lasts exactly DIV cycles, then -> BLANK.
REQ-018 BLANK: en=3'b000, seg=0; sel advances on BLANK entry edge, so sel never changes while en=3'b100; lasts exactly DEAD cycles, then -> DRIVE.
REQ-019 sel advance is modulo 8 (7 -> 0 wrap).
REQ-020 frame_done = 1 for exactly the one cycle following the wrap edge 7 -> 0; otherwise 0.
REQ-021 run=0 in DRIVE or BLANK -> IDLE next edge, sel held, counter cleared; re-run resumes at DRIVE on same sel.
REQ-022 Frame period (all digits enabled) = 8*(DIV+DEAD) cycles.
REQ-023 Simultaneous write and display of same digit: display shows old value that cycle, new value next cycle.

Reset
REQ-024 rst=1 asynchronously forces: state IDLE, counter 0, sel=0, en=3'b000, seg=0, frame_done=0, all register-file entries 0.
REQ-025 Reset asserted mid-DRIVE drives en=3'b000 immediately, without waiting for clk.
REQ-026 After rst release, first DRIVE begins on the edge after run is sampled 1.

Configuration
REQ-027 Macro SCAN_SKIP_EN defined: on BLANK entry sel advances to next index (mod 8, ascending) with digit_mask bit 1; frame_done pulses when this advance wraps past 7; if digit_mask = 0, FSM stays in or returns to IDLE.
REQ-028 SCAN_SKIP_EN undefined: every digit scanned in order; masked digits get full DIV+DEAD slot with en=3'b100 and seg=0.

Verification
REQ-029 rst pulse mid-DRIVE -> en=3'b000, seg=0, sel=0 asynchronously; reg file reads 0.
REQ-030 DIV=4, DEAD=1, mask=8'hFF, write reg[i]=i, run=1 -> sel 0..7 each 4 cycles en=3'b100 then 1 cycle en=3'b000; seg on sel=1 is 7'h06; frame_done once per 40 cycles.
REQ-031 During DRIVE of sel=3 write wr_addr=3 wr_data=8 -> seg changes to 7'h7F the cycle after the write edge.
REQ-032 run dropped while sel=5 -> IDLE, en=3'b000, sel stays 5; run=1 -> DRIVE resumes at sel=5.
REQ-033 SCAN_SKIP_EN, mask=8'b1000_0101 -> sel sequence 0,2,7,0,...; frame_done on each 7->0 advance; mask=0 -> en stays 3'b000.
REQ-034 SCAN_SKIP_EN undefined, mask=8'hFE -> sel=0 slot present, seg=0, en=3'b100 for 4 cycles.
